// File: rtl/layer_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : layer_reg_pkg
// Purpose  : Shared types and sizing constants for the per-layer header
//            register file and its command sequencer.
// Contents : layer_cmd_op_e command encoding, address/data widths,
//            layer and register counts.
// Revision : 1.0 - initial release
// ============================================================================
package layer_reg_pkg;

    localparam int LAYER_ADDR_W     = 5;
    localparam int LAYER_REG_SEL_W  = 3;
    localparam int LAYER_REG_DATA_W = 16;
    localparam int NUM_LAYERS       = 32;
    localparam int NUM_LAYER_REGS   = 8;

    typedef enum logic [1:0] {
        OP_WRITE       = 2'd0,
        OP_READ        = 2'd1,
        OP_CLEAR_LAYER = 2'd2,
        OP_CLEAR_ALL   = 2'd3
    } layer_cmd_op_e;

endpackage
`default_nettype wire

// File: rtl/layer_reg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : layer_reg_sequencer_if
// Purpose  : Command / response handshake bundle between the host and the
//            layer register sequencer.
// Ports    : cmd_valid/cmd_ready with cmd_op, cmd_layer, cmd_register,
//            cmd_data; rsp_valid/rsp_ready with rsp_data.
//            master = host side, slave = sequencer side.
// Revision : 1.0 - initial release
// ============================================================================
interface layer_reg_sequencer_if;
    import layer_reg_pkg::*;

    logic                         cmd_valid;
    logic                         cmd_ready;
    logic [1:0]                   cmd_op;
    logic [LAYER_ADDR_W-1:0]      cmd_layer;
    logic [LAYER_REG_SEL_W-1:0]   cmd_register;
    logic [LAYER_REG_DATA_W-1:0]  cmd_data;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [LAYER_REG_DATA_W-1:0]  rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_layer, cmd_register, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_layer, cmd_register, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface
`default_nettype wire

// File: rtl/layer_reg_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : layer_reg_sequencer
// Purpose  : Turns one host command at a time (write, read, clear layer,
//            clear all layers) into register-file controller strobes.
// Ports    : clk, rst (async, active high)
//            bus             - slave side of the command/response handshake
//            busy            - sequencer not idle
//            reg_layer       - register file layer address
//            reg_register    - register select within the layer
//            reg_write_en    - write strobe
//            reg_write_data  - write data (zero outside writes)
//            reg_rst_layer_n - active-low layer reset
//            reg_read_data   - read data, READ_LATENCY edges after address
// Revision : 1.0 - initial release
// ============================================================================
module layer_reg_sequencer
    import layer_reg_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int NUM_LAYERS   = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    layer_reg_sequencer_if.slave         bus,
    output logic                         busy,
    output logic [LAYER_ADDR_W-1:0]      reg_layer,
    output logic [LAYER_REG_SEL_W-1:0]   reg_register,
    output logic                         reg_write_en,
    output logic [LAYER_REG_DATA_W-1:0]  reg_write_data,
    output logic                         reg_rst_layer_n,
    input  logic [LAYER_REG_DATA_W-1:0]  reg_read_data
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WRITE     = 3'd1,
        ST_CLEAR     = 3'd2,
        ST_CLEAR_ALL = 3'd3,
        ST_READ_WAIT = 3'd4,
        ST_RESP      = 3'd5
    } state_e;

    localparam logic [LAYER_ADDR_W-1:0] c_last_layer = LAYER_ADDR_W'(NUM_LAYERS - 1);
    localparam logic [2:0]              c_lat_last   = 3'(READ_LATENCY);

    state_e     r_state;
    logic [2:0] r_lat_cnt;

    // reg_layer doubles as the clear-all walk counter, so the layer
    // address presented to the register file is always the counter itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_lat_cnt       <= 3'd0;
            bus.cmd_ready   <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_data    <= '0;
            busy            <= 1'b0;
            reg_layer       <= '0;
            reg_register    <= '0;
            reg_write_en    <= 1'b0;
            reg_write_data  <= '0;
            reg_rst_layer_n <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.cmd_ready <= 1'b0;
                        busy          <= 1'b1;
                        case (layer_cmd_op_e'(bus.cmd_op))
                            OP_WRITE: begin
                                r_state        <= ST_WRITE;
                                reg_layer      <= bus.cmd_layer;
                                reg_register   <= bus.cmd_register;
                                reg_write_data <= bus.cmd_data;
                                reg_write_en   <= 1'b1;
                            end
                            OP_READ: begin
                                r_state      <= ST_READ_WAIT;
                                reg_layer    <= bus.cmd_layer;
                                reg_register <= bus.cmd_register;
                                r_lat_cnt    <= 3'd0;
                            end
                            OP_CLEAR_LAYER: begin
                                r_state         <= ST_CLEAR;
                                reg_layer       <= bus.cmd_layer;
                                reg_rst_layer_n <= 1'b0;
                            end
                            OP_CLEAR_ALL: begin
                                r_state         <= ST_CLEAR_ALL;
                                reg_layer       <= '0;
                                reg_rst_layer_n <= 1'b0;
                            end
                        endcase
                    end else begin
                        // First edge out of reset raises ready.
                        bus.cmd_ready <= 1'b1;
                    end
                end

                ST_WRITE, ST_CLEAR: begin
                    reg_write_en    <= 1'b0;
                    reg_write_data  <= '0;
                    reg_rst_layer_n <= 1'b1;
                    r_state         <= ST_IDLE;
                    busy            <= 1'b0;
                    bus.cmd_ready   <= 1'b1;
                end

                ST_CLEAR_ALL: begin
                    // Incrementing past the last layer wraps the counter to 0
                    // exactly on exit.
                    reg_layer <= reg_layer + 1'b1;
                    if (reg_layer == c_last_layer) begin
                        reg_rst_layer_n <= 1'b1;
                        r_state         <= ST_IDLE;
                        busy            <= 1'b0;
                        bus.cmd_ready   <= 1'b1;
                    end
                end

                ST_READ_WAIT: begin
                    // READ_LATENCY+1 edges: one for the register file to
                    // sample the address, READ_LATENCY for its pipeline.
                    if (r_lat_cnt == c_lat_last) begin
                        bus.rsp_data  <= reg_read_data;
                        bus.rsp_valid <= 1'b1;
                        r_state       <= ST_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end

                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        r_state       <= ST_IDLE;
                        busy          <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state         <= ST_IDLE;
                    busy            <= 1'b0;
                    bus.cmd_ready   <= 1'b1;
                    bus.rsp_valid   <= 1'b0;
                    reg_write_en    <= 1'b0;
                    reg_write_data  <= '0;
                    reg_rst_layer_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layer_reg_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_layer_reg_sequencer
// Purpose  : Self-checking bench for layer_reg_sequencer. Lane A
//            (READ_LATENCY=3) runs against a transaction-timeline model with
//            a scoreboard memory; lane B (READ_LATENCY=1) checks read timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_reg_sequencer;
    import layer_reg_pkg::*;

    localparam int RL_A = 3;
    localparam int RL_B = 1;
    localparam int TO   = 400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- lane A ----------------
    layer_reg_sequencer_if if_a ();
    logic        busy_a, we_a, rstn_a;
    logic [4:0]  layer_a;
    logic [2:0]  regsel_a;
    logic [15:0] wd_a, rd_a;

    layer_reg_sequencer #(.READ_LATENCY(RL_A), .NUM_LAYERS(32)) u_dut_a (
        .clk(clk), .rst(rst), .bus(if_a), .busy(busy_a),
        .reg_layer(layer_a), .reg_register(regsel_a), .reg_write_en(we_a),
        .reg_write_data(wd_a), .reg_rst_layer_n(rstn_a), .reg_read_data(rd_a)
    );

    // Register file model driven by the DUT's controller pins.
    logic [15:0] mem_a  [32][8];
    logic [15:0] pipe_a [8];
    always @(posedge clk) begin
        if (we_a) mem_a[layer_a][regsel_a] <= wd_a;
        if (!rstn_a) for (int r = 0; r < 8; r++) mem_a[layer_a][r] <= 16'h0;
        pipe_a[0] <= mem_a[layer_a][regsel_a];
        for (int i = 1; i < 8; i++) pipe_a[i] <= pipe_a[i-1];
    end
    assign rd_a = pipe_a[RL_A-1];

    // Behavioural model: active command plus edges elapsed since acceptance.
    logic        m_act   = 1'b0;
    logic        m_ready = 1'b0;
    logic        m_rspv  = 1'b0;
    int          m_t     = 0;
    logic [1:0]  m_op    = 2'd0;
    logic [4:0]  m_layer = '0;
    logic [2:0]  m_reg   = '0;
    logic [15:0] m_data  = '0;
    logic [15:0] m_exp   = '0;
    logic [15:0] m_rspd  = '0;
    logic [15:0] sb [32][8];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act <= 1'b0; m_ready <= 1'b0; m_rspv <= 1'b0; m_t <= 0; m_rspd <= '0;
        end else if (!m_act) begin
            if (if_a.cmd_valid && m_ready) begin
                m_act <= 1'b1; m_ready <= 1'b0; m_t <= 0;
                m_op <= if_a.cmd_op; m_layer <= if_a.cmd_layer;
                m_reg <= if_a.cmd_register; m_data <= if_a.cmd_data;
                case (if_a.cmd_op)
                    2'd0: sb[if_a.cmd_layer][if_a.cmd_register] <= if_a.cmd_data;
                    2'd1: m_exp <= sb[if_a.cmd_layer][if_a.cmd_register];
                    2'd2: for (int r = 0; r < 8; r++) sb[if_a.cmd_layer][r] <= '0;
                    default: for (int l = 0; l < 32; l++)
                                 for (int r = 0; r < 8; r++) sb[l][r] <= '0;
                endcase
            end else begin
                m_ready <= 1'b1;
            end
        end else begin
            m_t <= m_t + 1;
            if (m_op == 2'd1) begin
                if (m_rspv) begin
                    if (if_a.rsp_ready) begin
                        m_rspv <= 1'b0; m_act <= 1'b0; m_ready <= 1'b1;
                    end
                end else if (m_t + 1 == RL_A + 1) begin
                    m_rspv <= 1'b1; m_rspd <= m_exp;
                end
            end else if (m_t + 1 == ((m_op == 2'd3) ? NUM_LAYERS : 1)) begin
                m_act <= 1'b0; m_ready <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin : p_compare
        logic sw, sc, rw;
        sw = m_act && (m_op == 2'd0) && (m_t == 0);
        sc = m_act && (((m_op == 2'd2) && (m_t == 0)) || (m_op == 2'd3));
        rw = m_act && (m_op == 2'd1) && !m_rspv;
        chk("cmd_ready", if_a.cmd_ready, m_ready);
        chk("busy", busy_a, m_act);
        chk("rsp_valid", if_a.rsp_valid, m_rspv);
        if (m_rspv) chk("rsp_data", if_a.rsp_data, m_rspd);
        chk("write_en", we_a, sw);
        chk("write_data", wd_a, sw ? m_data : 16'h0);
        chk("rst_layer_n", rstn_a, !sc);
        if (sw || rw || (m_act && m_op == 2'd2 && m_t == 0)) chk("reg_layer", layer_a, m_layer);
        if (m_act && m_op == 2'd3) chk("clear_all_layer", layer_a, m_t[4:0]);
        if (sw || rw) chk("reg_register", regsel_a, m_reg);
    end

    int strobe_cnt = 0;
    int rsp_cnt    = 0;
    always @(negedge clk) if (we_a) strobe_cnt <= strobe_cnt + 1;
    always @(posedge clk) if (if_a.rsp_valid && if_a.rsp_ready) rsp_cnt <= rsp_cnt + 1;

    int rr_mode = 0;  // 0: rsp_ready low, 1: high, 2: random
    initial begin
        if_a.rsp_ready = 1'b0;
        forever begin
            @(negedge clk); #1;
            case (rr_mode)
                0:       if_a.rsp_ready = 1'b0;
                1:       if_a.rsp_ready = 1'b1;
                default: if_a.rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Called at a negedge; returns at the negedge just after acceptance.
    task automatic send_a(input logic [1:0] op, input logic [4:0] l, input logic [2:0] r,
                          input logic [15:0] d, input bit keep);
        int n;
        n = 0;
        if_a.cmd_valid = 1'b1; if_a.cmd_op = op; if_a.cmd_layer = l;
        if_a.cmd_register = r; if_a.cmd_data = d;
        while (!if_a.cmd_ready && n < TO) begin @(negedge clk); n++; end
        if (n >= TO) chk("send_timeout", 1, 0);
        @(negedge clk);
        if (!keep) begin
            if_a.cmd_valid = 1'b0;
            if_a.cmd_op = 2'($urandom); if_a.cmd_layer = 5'($urandom);
            if_a.cmd_register = 3'($urandom); if_a.cmd_data = 16'($urandom);
        end
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        while ((busy_a || !if_a.cmd_ready) && n < TO) begin @(negedge clk); n++; end
        if (n >= TO) chk("idle_timeout", 1, 0);
    endtask

    task automatic read_a(input logic [4:0] l, input logic [2:0] r, output logic [15:0] d);
        int n;
        n = 0;
        send_a(2'd1, l, r, 16'h0, 1'b0);
        while (!if_a.rsp_valid && n < 50) begin @(negedge clk); n++; end
        if (n >= 50) chk("rsp_timeout", 1, 0);
        d = if_a.rsp_data;
        wait_idle_a();
    endtask

    // ---------------- lane B ----------------
    layer_reg_sequencer_if if_b ();
    logic        busy_b, we_b, rstn_b;
    logic [4:0]  layer_b;
    logic [2:0]  regsel_b;
    logic [15:0] wd_b, rd_b;

    layer_reg_sequencer #(.READ_LATENCY(RL_B), .NUM_LAYERS(32)) u_dut_b (
        .clk(clk), .rst(rst), .bus(if_b), .busy(busy_b),
        .reg_layer(layer_b), .reg_register(regsel_b), .reg_write_en(we_b),
        .reg_write_data(wd_b), .reg_rst_layer_n(rstn_b), .reg_read_data(rd_b)
    );

    logic [15:0] mem_b [32][8];
    logic [15:0] pipe_b;
    always @(posedge clk) begin
        if (we_b) mem_b[layer_b][regsel_b] <= wd_b;
        if (!rstn_b) for (int r = 0; r < 8; r++) mem_b[layer_b][r] <= 16'h0;
        pipe_b <= mem_b[layer_b][regsel_b];
    end
    assign rd_b = pipe_b;

    task automatic send_b(input logic [1:0] op, input logic [4:0] l, input logic [2:0] r,
                          input logic [15:0] d);
        int n;
        n = 0;
        if_b.cmd_valid = 1'b1; if_b.cmd_op = op; if_b.cmd_layer = l;
        if_b.cmd_register = r; if_b.cmd_data = d;
        while (!if_b.cmd_ready && n < TO) begin @(negedge clk); n++; end
        if (n >= TO) chk("send_b_timeout", 1, 0);
        @(negedge clk);
        if_b.cmd_valid = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] d;
        int cnt, gaps, s_w, s_r, nw, nr;
        if_a.cmd_valid = 1'b0; if_a.cmd_op = 2'd0; if_a.cmd_layer = '0;
        if_a.cmd_register = '0; if_a.cmd_data = '0;
        if_b.cmd_valid = 1'b0; if_b.cmd_op = 2'd0; if_b.cmd_layer = '0;
        if_b.cmd_register = '0; if_b.cmd_data = '0; if_b.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", if_a.cmd_ready, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_rsp_valid", if_a.rsp_valid, 0);
        chk("rst_rsp_data", if_a.rsp_data, 0);
        chk("rst_reg_layer", layer_a, 0);
        chk("rst_reg_register", regsel_a, 0);
        chk("rst_write_en", we_a, 0);
        chk("rst_write_data", wd_a, 0);
        chk("rst_rst_layer_n", rstn_a, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", if_a.cmd_ready, 1);

        // WRITE layer 7 reg 3 = 0xBEEF
        send_a(2'd0, 5'd7, 3'd3, 16'hBEEF, 1'b0);
        chk("wr_en", we_a, 1);
        chk("wr_layer", layer_a, 7);
        chk("wr_reg", regsel_a, 3);
        chk("wr_data", wd_a, 16'hBEEF);
        chk("wr_ready_low", if_a.cmd_ready, 0);
        @(negedge clk);
        chk("wr_en_done", we_a, 0);
        chk("wr_ready_back", if_a.cmd_ready, 1);

        // READ with consumer stalled
        rr_mode = 0;
        send_a(2'd1, 5'd7, 3'd3, 16'h0, 1'b0);
        repeat (RL_A) @(negedge clk);
        chk("rd_valid_early", if_a.rsp_valid, 0);
        @(negedge clk);
        chk("rd_valid", if_a.rsp_valid, 1);
        chk("rd_data", if_a.rsp_data, 16'hBEEF);
        repeat (5) begin
            @(negedge clk);
            chk("rd_hold_valid", if_a.rsp_valid, 1);
            chk("rd_hold_data", if_a.rsp_data, 16'hBEEF);
            chk("rd_hold_ready", if_a.cmd_ready, 0);
        end
        rr_mode = 1;
        wait_idle_a();

        // CLEAR_ALL walk
        send_a(2'd3, 5'd9, 3'd0, 16'h0, 1'b0);
        cnt = 0; gaps = 0;
        while (!rstn_a && cnt < 40) begin
            if (layer_a != 5'(cnt)) gaps++;
            cnt++;
            @(negedge clk);
        end
        chk("clear_all_len", cnt, 32);
        chk("clear_all_seq_errs", gaps, 0);
        wait_idle_a();
        read_a(5'd7, 3'd3, d);  chk("clear_all_rd_7_3", d, 0);
        read_a(5'd31, 3'd7, d); chk("clear_all_rd_31_7", d, 0);

        // CLEAR_LAYER isolation
        send_a(2'd0, 5'd12, 3'd0, 16'h1234, 1'b0); wait_idle_a();
        send_a(2'd0, 5'd13, 3'd0, 16'h1234, 1'b0); wait_idle_a();
        send_a(2'd2, 5'd12, 3'd5, 16'hFFFF, 1'b0); wait_idle_a();
        read_a(5'd12, 3'd0, d); chk("clr_layer12", d, 0);
        read_a(5'd13, 3'd0, d); chk("keep_layer13", d, 16'h1234);

        // Reset partway through CLEAR_ALL
        send_a(2'd3, 5'd0, 3'd0, 16'h0, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_cmd_ready", if_a.cmd_ready, 0);
        chk("arst_busy", busy_a, 0);
        chk("arst_rst_layer_n", rstn_a, 1);
        chk("arst_reg_layer", layer_a, 0);
        chk("arst_rsp_valid", if_a.rsp_valid, 0);
        chk("arst_write_en", we_a, 0);
        @(negedge clk);
        rst = 1'b0;
        chk("arst_ready_before_edge", if_a.cmd_ready, 0);
        @(negedge clk);
        chk("arst_ready_after_edge", if_a.cmd_ready, 1);
        send_a(2'd3, 5'd17, 3'd0, 16'h0, 1'b0);
        chk("restart_layer0", layer_a, 0);
        chk("restart_rstn", rstn_a, 0);
        wait_idle_a();

        // cmd_valid held high, alternating WRITE/READ
        rr_mode = 2;
        s_w = strobe_cnt; s_r = rsp_cnt; nw = 0; nr = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) nw++; else nr++;
            send_a((i % 2 == 0) ? 2'd0 : 2'd1, 5'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   16'($urandom), (i != 19));
        end
        wait_idle_a();
        @(negedge clk);
        chk("alt_strobes", strobe_cnt - s_w, nw);
        chk("alt_responses", rsp_cnt - s_r, nr);

        // Randomized traffic
        for (int i = 0; i < 200; i++) begin
            int sel;
            logic [1:0] op;
            sel = $urandom_range(0, 19);
            op = (sel < 8) ? 2'd0 : (sel < 15) ? 2'd1 : (sel < 19) ? 2'd2 : 2'd3;
            send_a(op, ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3)),
                   3'($urandom_range(0, 7)), 16'($urandom), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        if_a.cmd_valid = 1'b0;
        wait_idle_a();

        // Lane B: READ_LATENCY=1 timing with rsp_ready already high
        send_b(2'd0, 5'd7, 3'd3, 16'hBEEF);
        chk("b_wr_en", we_b, 1);
        @(negedge clk);
        if_b.rsp_ready = 1'b1;
        send_b(2'd1, 5'd7, 3'd3, 16'h0);
        chk("b_valid_k0", if_b.rsp_valid, 0);
        @(negedge clk);
        chk("b_valid_k1", if_b.rsp_valid, 0);
        @(negedge clk);
        chk("b_valid_k2", if_b.rsp_valid, 1);
        chk("b_data", if_b.rsp_data, 16'hBEEF);
        chk("b_ready_k2", if_b.cmd_ready, 0);
        @(negedge clk);
        chk("b_valid_k3", if_b.rsp_valid, 0);
        chk("b_ready_k3", if_b.cmd_ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layer_reg_sequencer.md
# layer_reg_sequencer

Command sequencer between the host/controller bus and the per-layer header register file (32 layers × 8 × 16-bit registers). It accepts one command at a time over a valid/ready interface and turns it into the register file's controller-port signals. Commands are write, read, clear one layer, or clear all layers. Reads return data over a held response handshake. Clear-all walks every layer automatically, so firmware never loops over layer resets itself.

## Interface
Parameters:
- `READ_LATENCY`, default 1: number of clock edges from the register file sampling `reg_layer`/`reg_register` to `reg_read_data` being valid. Legal range 0..7.
- `NUM_LAYERS`, default 32: layers walked by CLEAR_ALL. Must equal 2^5.

Ports:
- `clk`  in  1  sequencer clock. One clock domain only.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  sequencer can accept a command.
- `cmd_op`  in  2  0=WRITE, 1=READ, 2=CLEAR_LAYER, 3=CLEAR_ALL.
- `cmd_layer`  in  5  target layer. Ignored for CLEAR_ALL.
- `cmd_register`  in  3  target register within the layer. Used by WRITE and READ.
- `cmd_data`  in  16  write data. Used by WRITE.
- `rsp_valid`  out  1  read data available.
- `rsp_ready`  in  1  consumer takes the read data.
- `rsp_data`  out  16  read result.
- `busy`  out  1  sequencer is not in IDLE.
- `reg_layer`  out  5  register file controller layer address.
- `reg_register`  out  3  register file controller register select.
- `reg_write_en`  out  1  register file write strobe.
- `reg_write_data`  out  16  register file write data.
- `reg_rst_layer_n`  out  1  active-low layer reset to the register file.
- `reg_read_data`  in  16  register file controller read data.

## Operation
- States: IDLE, WRITE, CLEAR, CLEAR_ALL, READ_WAIT, RESP.
- A command is accepted on an edge where `cmd_valid && cmd_ready`. All `cmd_*` fields are latched at acceptance and are don't-care at any other time.
- `cmd_ready` is 1 only in IDLE, and only once reset has been released.
- IDLE → WRITE (op 0): drive `reg_write_en`=1 with the latched layer, register and data for exactly one cycle, then → IDLE.
- IDLE → CLEAR (op 2): drive `reg_rst_layer_n`=0 with `reg_layer`=latched layer for exactly one cycle, then → IDLE.
- IDLE → CLEAR_ALL (op 3):
  - Drive `reg_rst_layer_n`=0 while `reg_layer` steps 0,1,…,31, one layer per cycle (32 cycles).
  - Leave after layer 31 → IDLE.
  - The 5-bit layer counter wraps 31→0 on exit only; layers are never revisited.
- IDLE → READ_WAIT (op 1):
  - Hold `reg_layer`/`reg_register` steady and count READ_LATENCY+1 cycles.
  - Capture `reg_read_data` into `rsp_data`, then → RESP.
- RESP: `rsp_valid`=1 and `rsp_data` stable until an edge with `rsp_ready`=1. On that edge → IDLE and `rsp_valid`=0. `rsp_ready` is ignored while `rsp_valid`=0.
- `reg_write_en`=0 and `reg_write_data`=0 in every state except WRITE.
- `reg_rst_layer_n`=1 in every state except CLEAR and CLEAR_ALL.
- `reg_write_en` and `reg_rst_layer_n`=0 are never active in the same cycle.
- `busy` = (state ≠ IDLE).
- Reset mid-command (including partway through CLEAR_ALL or while waiting in RESP): everything is abandoned. Nothing resumes, and the pending response is lost.

## Timing
- All outputs are registered.
- Reset values: `cmd_ready`=0, `busy`=0, `rsp_valid`=0, `rsp_data`=0, `reg_layer`=0, `reg_register`=0, `reg_write_en`=0, `reg_write_data`=0, `reg_rst_layer_n`=1.
- `cmd_ready` goes to 1 at the first `clk` edge after `rst` deasserts.
- Command accepted at edge k:
  - `cmd_ready`=0 from edge k.
  - WRITE and CLEAR strobe between edges k and k+1. `cmd_ready`=1 again after k+1, giving 2 cycles per command.
  - CLEAR_ALL: `reg_rst_layer_n`=0 between edges k and k+32. `cmd_ready`=1 after k+32.
  - READ: `rsp_data` is captured and `rsp_valid`=1 after edge k+READ_LATENCY+1.
  - If `rsp_ready` is already high, `rsp_valid` falls and `cmd_ready` rises together at edge k+READ_LATENCY+2.
- Back-to-back commands: the next command may be accepted on the edge at which `cmd_ready` first reads 1 again. There are no overlapping operations.

## Structure
- Shared package `layer_reg_pkg` holds:
  - enum `layer_cmd_op_e` (WRITE, READ, CLEAR_LAYER, CLEAR_ALL);
  - constants `LAYER_ADDR_W`=5, `LAYER_REG_SEL_W`=3, `LAYER_REG_DATA_W`=16, `NUM_LAYERS`=32, `NUM_LAYER_REGS`=8.
- The state enum stays local to the module.
- Single module, no sub-module: one FSM, a 5-bit layer counter and a 3-bit latency counter.

## Test plan
- WRITE layer 7, reg 3, data 0xBEEF → one cycle with `reg_write_en`=1, `reg_layer`=7, `reg_register`=3, `reg_write_data`=0xBEEF; `cmd_ready`=1 two cycles after acceptance.
- READ layer 7, reg 3 against a model returning 0xBEEF with READ_LATENCY=1 and 3 → `rsp_valid` after edge k+2 and k+4 respectively, `rsp_data`=0xBEEF. Hold `rsp_ready`=0 for 5 cycles → data stable and `cmd_ready`=0 throughout.
- CLEAR_ALL → `reg_rst_layer_n`=0 for exactly 32 cycles, `reg_layer` sequence 0..31 with no gaps, `reg_write_en` never 1. Then READ any layer/register from the model → 0x0000.
- CLEAR_LAYER 12 after writing 0x1234 to layer 12 reg 0 and layer 13 reg 0 → layer 12 reads 0, layer 13 reads 0x1234.
- Assert `rst` at cycle 10 of CLEAR_ALL → all outputs at reset values immediately (asynchronous). After release, `cmd_ready`=1 on the next edge and the counter restarts at 0 on a new CLEAR_ALL.
- `cmd_valid` held high with alternating WRITE/READ while `cmd_ready`=0 → no command accepted outside IDLE; every accepted command produces exactly one strobe or one response.
